nrzi_stuff_enc: RTL

NRZI_STUFF_ENC -- requirements
Module: nrzi_stuff_enc

---
 rtl/nrzi_stuff_enc_if.sv | 22 ++
 rtl/nrzi_stuff_enc.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/nrzi_stuff_enc_if.sv
// Bit-serial packet stream into the NRZI encoder, plus the line-level outputs to the DP/DM writer.
// The master drives packet bits; the slave is the encoder.
interface nrzi_stuff_enc_if;
    logic       in_bit;
    logic       in_valid;
    logic [1:0] in_type;
    logic       in_last;
    logic       in_ready;
    logic       out_bit;
    logic [1:0] out_ready;
    logic       err;

    modport master (
        output in_bit, in_valid, in_type, in_last,
        input  in_ready, out_bit, out_ready, err
    );

    modport slave (
        input  in_bit, in_valid, in_type, in_last,
        output in_ready, out_bit, out_ready, err
    );
endinterface

// File: rtl/nrzi_stuff_enc.sv
// NRZI line encoder with SYNC generation, bit stuffing and a post-packet tail; all outputs registered.
// Each bit appears 1 cycle after acceptance; in_ready is low in SYNC/STUFF/TAIL, and in_valid low in DATA aborts the packet.
module nrzi_stuff_enc #(
    parameter int RUN_MAX  = 6,
    parameter int TAIL_LEN = 3
) (
    input  logic              clk,
    input  logic              rst_b,
    nrzi_stuff_enc_if.slave   bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SYNC  = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STUFF = 3'd3;
    localparam logic [2:0] S_TAIL  = 3'd4;

    localparam int         TW        = (TAIL_LEN < 2) ? 1 : $clog2(TAIL_LEN + 1);
    localparam logic [2:0] RUN_MAX_W = 3'(RUN_MAX);
    localparam logic [TW-1:0] TAIL_LAST = TW'(TAIL_LEN);

    logic [2:0]    state;
    logic          level;
    logic [2:0]    run;
    logic [2:0]    sync_cnt;
    logic [TW-1:0] tail_cnt;
    logic [1:0]    pkt_type;
    logic          pend_last;
    logic          out_bit_q;
    logic [1:0]    out_ready_q;
    logic          in_ready_q;
    logic          err_q;

    logic          sync_lvl;
    logic          data_lvl;
    logic [2:0]    run_inc;

    always_comb begin
        sync_lvl = (sync_cnt == 3'd7) ? level : ~level;
        data_lvl = bus.in_bit ? level : ~level;
        run_inc  = (run >= RUN_MAX_W) ? RUN_MAX_W : run + 3'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state       <= S_IDLE;
            level       <= 1'b1;
            run         <= 3'd0;
            sync_cnt    <= 3'd0;
            tail_cnt    <= '0;
            pkt_type    <= 2'b00;
            pend_last   <= 1'b0;
            out_bit_q   <= 1'b1;
            out_ready_q <= 2'b00;
            in_ready_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    // The start edge already emits the first SYNC bit (a 0 from level 1) to meet 1-cycle latency.
                    if (bus.in_valid && bus.in_type != 2'b00) begin
                        pkt_type    <= bus.in_type;
                        out_ready_q <= bus.in_type;
                        level       <= 1'b0;
                        out_bit_q   <= 1'b0;
                        sync_cnt    <= 3'd1;
                        state       <= S_SYNC;
                    end
                end
                S_SYNC: begin
                    level     <= sync_lvl;
                    out_bit_q <= sync_lvl;
                    sync_cnt  <= sync_cnt + 3'd1;
                    if (sync_cnt == 3'd7) begin
                        run        <= 3'd1;
                        in_ready_q <= 1'b1;
                        state      <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (bus.in_valid) begin
                        level     <= data_lvl;
                        out_bit_q <= data_lvl;
                        run       <= bus.in_bit ? run_inc : 3'd0;
                        if (bus.in_bit && run_inc == RUN_MAX_W) begin
                            pend_last  <= bus.in_last;
                            in_ready_q <= 1'b0;
                            state      <= S_STUFF;
                        end else if (bus.in_last) begin
                            tail_cnt   <= '0;
                            in_ready_q <= 1'b0;
                            state      <= S_TAIL;
                        end
                    end else begin
                        // Underflow: the abort cycle itself counts as the first tail cycle.
                        err_q      <= 1'b1;
                        out_bit_q  <= 1'b1;
                        tail_cnt   <= TW'(1);
                        in_ready_q <= 1'b0;
                        state      <= S_TAIL;
                    end
                end
                S_STUFF: begin
                    level     <= ~level;
                    out_bit_q <= ~level;
                    run       <= 3'd0;
                    if (pend_last) begin
                        tail_cnt <= '0;
                        state    <= S_TAIL;
                    end else begin
                        in_ready_q <= 1'b1;
                        state      <= S_DATA;
                    end
                end
                S_TAIL: begin
                    out_bit_q <= 1'b1;
                    if (tail_cnt == TAIL_LAST) begin
                        out_ready_q <= 2'b00;
                        pkt_type    <= 2'b00;
                        level       <= 1'b1;
                        run         <= 3'd0;
                        pend_last   <= 1'b0;
                        state       <= S_IDLE;
                    end else begin
                        tail_cnt <= tail_cnt + 1'b1;
                    end
                end
                default: begin
                    out_bit_q   <= 1'b1;
                    out_ready_q <= 2'b00;
                    in_ready_q  <= 1'b0;
                    state       <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.out_bit   = out_bit_q;
    assign bus.out_ready = out_ready_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.err       = err_q;
endmodule
